// File: rtl/alu_pkg.sv
// Shared ALU definitions: add-class op encoding, sequencer states, EX constants
// and the EX-word rule for the four add-class instructions.
package alu_pkg;

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_ADX = 2'd2, OP_SBX = 2'd3} op_e;
  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_FIN} state_e;

  localparam logic [15:0] EX_ZERO   = 16'h0000;
  localparam logic [15:0] EX_CARRY  = 16'h0001;
  localparam logic [15:0] EX_BORROW = 16'hFFFF;

  // c1/c2 are the pass carries (c2=0 for single-pass ops); ex_msb is the sign of the old EX.
  function automatic logic [15:0] ex_word(op_e o, logic c1, logic c2, logic ex_msb);
    logic signed [2:0] h;
    logic [15:0] r;
    h = $signed({2'b00, c2}) - $signed({2'b00, ex_msb}) - $signed({2'b00, ~c1});
    r = EX_ZERO;
    case (o)
      OP_ADD: r = c1 ? EX_CARRY : EX_ZERO;
      OP_SUB: r = c1 ? EX_ZERO : EX_BORROW;
      OP_ADX: r = (c1 | c2) ? EX_CARRY : EX_ZERO;
      OP_SBX: r = (h < 0) ? EX_BORROW : ((h > 0) ? EX_CARRY : EX_ZERO);
      default: r = EX_ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Start/done handshake and data bus between execute stage and the add-class sequencer.
interface addsub_seq_if;
  import alu_pkg::*;

  logic        start;
  op_e         op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] ex_in;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [15:0] ex_out;

  modport master (output start, op, a, b, ex_in, input busy, done, q, ex_out);
  modport slave  (input start, op, a, b, ex_in, output busy, done, q, ex_out);
endinterface

// File: rtl/add16.sv
// Plain 16-bit ripple/inferred adder with carry in and carry out.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

// File: rtl/addsub_seq.sv
// ADD/SUB/ADX/SBX sequencer: one or two passes through a single shared add16,
// results and EX written on entry to FIN so they are valid with done.
module addsub_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  addsub_seq_if.slave  bus
);

  state_e      state;
  op_e         op_r;
  logic [15:0] a_r, b_r, ex_r, r1;
  logic        c1;
  logic        busy_q, done_q;
  logic [15:0] q_q, ex_q;

  logic [15:0] add_a, add_b, add_s;
  logic        add_ci, add_co;
  logic        two_pass;

  assign two_pass = (op_r == OP_ADX) || (op_r == OP_SBX);

  // Second pass folds the old EX into the first-pass sum.
  always_comb begin
    add_a  = a_r;
    add_b  = b_r;
    add_ci = 1'b0;
    if (state == S_PASS2) begin
      add_a = r1;
      add_b = ex_r;
    end else if (op_r == OP_SUB || op_r == OP_SBX) begin
      add_b  = ~b_r;
      add_ci = 1'b1;
    end
  end

  add16 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_ci),
    .sum  (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_r   <= OP_ADD;
      a_r    <= '0;
      b_r    <= '0;
      ex_r   <= '0;
      r1     <= '0;
      c1     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      q_q    <= '0;
      ex_q   <= EX_ZERO;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: if (bus.start) begin
          op_r   <= bus.op;
          a_r    <= bus.a;
          b_r    <= bus.b;
          ex_r   <= bus.ex_in;
          busy_q <= 1'b1;
          state  <= S_PASS1;
        end
        S_PASS1: begin
          r1 <= add_s;
          c1 <= add_co;
          if (two_pass) state <= S_PASS2;
          else begin
            q_q    <= add_s;
            ex_q   <= ex_word(op_r, add_co, 1'b0, 1'b0);
            done_q <= 1'b1;
            state  <= S_FIN;
          end
        end
        S_PASS2: begin
          q_q    <= add_s;
          ex_q   <= ex_word(op_r, c1, add_co, ex_r[15]);
          done_q <= 1'b1;
          state  <= S_FIN;
        end
        S_FIN: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.q      = q_q;
  assign bus.ex_out = ex_q;

endmodule
